// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file constants, write-port FSM states and helpers
package regfile_pkg;

   localparam int RF_DW    = 8;
   localparam int RF_AW    = 3;
   localparam int RF_NREGS = 2 ** RF_AW;
   localparam int REG_ZERO = 0;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } wr_state_e;

   // Width of an index into n requesters; never narrower than one bit.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational one-hot round-robin pick starting at rr_ptr
module rr_arbiter #(
   parameter int NREQ = 3,
   parameter int PW   = 2
) (
   input  logic [NREQ-1:0] req_valid,
   input  logic [PW-1:0]   rr_ptr,
   output logic [NREQ-1:0] grant,
   output logic [PW-1:0]   grant_idx,
   output logic            grant_valid
);

   logic [PW:0]   sum;
   logic [PW-1:0] idx;

   always_comb begin
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      sum         = '0;
      idx         = '0;
      for (int k = 0; k < NREQ; k++) begin
         sum = {1'b0, rr_ptr} + (PW+1)'(k);
         if (sum >= (PW+1)'(NREQ)) begin
            sum = sum - (PW+1)'(NREQ);
         end
         idx = sum[PW-1:0];
         if (!grant_valid && req_valid[idx]) begin
            grant_valid = 1'b1;
            grant_idx   = idx;
            grant[idx]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - register-file write-port owner: zero-fill after reset, then round-robin writeback
module regfile_write_arbiter #(
   parameter int NREQ = 3,
   parameter int DW   = regfile_pkg::RF_DW,
   parameter int AW   = regfile_pkg::RF_AW
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear_req,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_data,
   output logic [NREQ-1:0]   req_ready,
   output logic [AW-1:0]     wa3,
   output logic [DW-1:0]     wd3,
   output logic              we3,
   output logic              init_done,
   output logic              busy
);

   import regfile_pkg::*;

   localparam int NREGS = 2 ** AW;
   localparam int PW    = ptr_width(NREQ);

   wr_state_e     state_q, state_d;
   logic [AW-1:0] fill_cnt_q, fill_cnt_d;
   logic [PW-1:0] rr_ptr_q, rr_ptr_d;
   logic [AW-1:0] wa3_q, wa3_d;
   logic [DW-1:0] wd3_q, wd3_d;
   logic          we3_q, we3_d;
   logic          init_done_q, init_done_d;

   logic [NREQ-1:0] grant;
   logic [PW-1:0]   grant_idx;
   logic            grant_valid;
   logic            arb_open;
   logic [AW-1:0]   g_addr;
   logic [DW-1:0]   g_data;

   rr_arbiter #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_rr_arbiter (
      .req_valid   (req_valid),
      .rr_ptr      (rr_ptr_q),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   // A clear pulse in RUN suppresses the grant so nothing is consumed that cycle.
   assign arb_open  = (state_q == RUN) && !clear_req;
   assign req_ready = arb_open ? grant : '0;

   always_comb begin
      g_addr = '0;
      g_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_idx == PW'(i)) begin
            g_addr = req_addr[i*AW +: AW];
            g_data = req_data[i*DW +: DW];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      fill_cnt_d  = fill_cnt_q;
      rr_ptr_d    = rr_ptr_q;
      wa3_d       = wa3_q;
      wd3_d       = wd3_q;
      we3_d       = 1'b0;
      init_done_d = init_done_q;
      case (state_q)
         INIT: begin
            wa3_d = fill_cnt_q;
            wd3_d = '0;
            we3_d = 1'b1;
            if (clear_req) begin
               fill_cnt_d = AW'(1);
            end else if (fill_cnt_q == AW'(NREGS-1)) begin
               state_d     = RUN;
               init_done_d = 1'b1;
               fill_cnt_d  = AW'(1);
            end else begin
               fill_cnt_d = fill_cnt_q + AW'(1);
            end
         end
         RUN: begin
            if (clear_req) begin
               state_d     = INIT;
               fill_cnt_d  = AW'(1);
               init_done_d = 1'b0;
            end else if (grant_valid) begin
               wa3_d    = g_addr;
               wd3_d    = g_data;
               // r0 is hardwired zero: the request is consumed but never written.
               we3_d    = (g_addr != AW'(REG_ZERO));
               rr_ptr_d = (grant_idx == PW'(NREQ-1)) ? '0 : grant_idx + PW'(1);
            end
         end
         default: begin
            state_d = INIT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= INIT;
         fill_cnt_q  <= AW'(1);
         rr_ptr_q    <= '0;
         wa3_q       <= '0;
         wd3_q       <= '0;
         we3_q       <= 1'b0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         fill_cnt_q  <= fill_cnt_d;
         rr_ptr_q    <= rr_ptr_d;
         wa3_q       <= wa3_d;
         wd3_q       <= wd3_d;
         we3_q       <= we3_d;
         init_done_q <= init_done_d;
      end
   end

   assign wa3       = wa3_q;
   assign wd3       = wd3_q;
   assign we3       = we3_q;
   assign init_done = init_done_q;
   assign busy      = (state_q == INIT) || (|req_valid);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed and randomized checks of regfile_write_arbiter against a cycle model
module tb_regfile_write_arbiter;

   localparam int NREQ  = 3;
   localparam int DW    = 8;
   localparam int AW    = 3;
   localparam int NREGS = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic clear_req = 1'b0;
   logic [NREQ-1:0]    req_valid;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    req_ready;
   logic [AW-1:0]      wa3;
   logic [DW-1:0]      wd3;
   logic               we3;
   logic               init_done;
   logic               busy;

   logic          r_valid [NREQ] = '{default: 1'b0};
   logic [AW-1:0] r_addr  [NREQ] = '{default: '0};
   logic [DW-1:0] r_data  [NREQ] = '{default: '0};

   // Stand-in for RegisterFile, written only through the DUT's port.
   logic [DW-1:0] rf       [NREGS] = '{default: 8'hEE};
   logic [DW-1:0] model_rf [NREGS] = '{default: 8'hEE};

   int m_fill;
   int m_ptr;
   logic          cur_we;
   logic [AW-1:0] cur_wa;
   logic [DW-1:0] cur_wd;
   logic          cur_done;

   int vectors = 0;
   int errs    = 0;

   regfile_write_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear_req (clear_req),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_ready (req_ready),
      .wa3       (wa3),
      .wd3       (wd3),
      .we3       (we3),
      .init_done (init_done),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (we3) rf[wa3] <= wd3;
   end

   always_comb begin
      req_valid = '0;
      req_addr  = '0;
      req_data  = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i]           = r_valid[i];
         req_addr[i*AW +: AW]   = r_addr[i];
         req_data[i*DW +: DW]   = r_data[i];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int pick();
      for (int k = 0; k < NREQ; k++) begin
         if (r_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
      end
      return -1;
   endfunction

   function automatic logic any_valid();
      for (int i = 0; i < NREQ; i++) if (r_valid[i]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      m_fill   = 1;
      m_ptr    = 0;
      cur_we   = 1'b0;
      cur_wa   = '0;
      cur_wd   = '0;
      cur_done = 1'b0;
   endtask

   task automatic set_req(input int i, input int a, input int d);
      r_valid[i] = 1'b1;
      r_addr[i]  = AW'(a);
      r_data[i]  = DW'(d);
   endtask

   // One clock: compare what the previous cycle should have produced, predict this one, advance.
   task automatic run_cycle(output int g);
      logic          n_we, n_done;
      logic [AW-1:0] n_wa;
      logic [DW-1:0] n_wd;
      logic [NREQ-1:0] exp_ready;
      @(negedge clk);
      chk("we3", we3, cur_we);
      chk("wa3", wa3, cur_wa);
      chk("wd3", wd3, cur_wd);
      chk("init_done", init_done, cur_done);
      chk("busy", busy, (m_fill != 0) || any_valid());
      g      = -1;
      n_we   = 1'b0;
      n_wa   = cur_wa;
      n_wd   = cur_wd;
      n_done = cur_done;
      if (m_fill != 0) begin
         n_we = 1'b1;
         n_wa = AW'(m_fill);
         n_wd = '0;
         model_rf[m_fill] = '0;
         if (clear_req) m_fill = 1;
         else if (m_fill == NREGS - 1) begin
            m_fill = 0;
            n_done = 1'b1;
         end else m_fill++;
      end else if (clear_req) begin
         m_fill = 1;
         n_done = 1'b0;
      end else begin
         g = pick();
         if (g >= 0) begin
            n_wa = r_addr[g];
            n_wd = r_data[g];
            n_we = (r_addr[g] != 0);
            if (n_we) model_rf[r_addr[g]] = r_data[g];
            m_ptr = (g + 1) % NREQ;
         end
      end
      exp_ready = (g >= 0) ? NREQ'(1 << g) : '0;
      chk("req_ready", req_ready, exp_ready);
      @(posedge clk);
      #1;
      cur_we   = n_we;
      cur_wa   = n_wa;
      cur_wd   = n_wd;
      cur_done = n_done;
   endtask

   initial begin
      int g;
      model_reset();
      #2 rst_n = 1'b0;
      for (int i = 0; i < NREQ; i++) set_req(i, i + 1, 8'h70 + i);
      @(negedge clk);
      chk("rst_we3", we3, 1'b0);
      chk("rst_wa3", wa3, 0);
      chk("rst_wd3", wd3, 0);
      chk("rst_init_done", init_done, 1'b0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_busy", busy, 1'b1);
      for (int i = 0; i < NREQ; i++) r_valid[i] = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;

      // zero-fill of r1..r7
      repeat (9) run_cycle(g);
      chk("fill_r7", rf[7], 0);
      chk("fill_r1", rf[1], 0);

      // single write from requester 1
      set_req(1, 5, 8'hA3);
      run_cycle(g);
      chk("single_we3", we3, 1'b1);
      chk("single_wa3", wa3, 5);
      chk("single_wd3", wd3, 8'hA3);
      r_valid[1] = 1'b0;
      repeat (2) run_cycle(g);
      chk("single_rd1", rf[5], 8'hA3);

      // requester 2 write brings the pointer back to 0
      set_req(2, 6, 8'h66);
      run_cycle(g);
      r_valid[2] = 1'b0;
      run_cycle(g);

      // round-robin fairness with all three valid
      set_req(0, 2, 8'h11);
      set_req(1, 3, 8'h22);
      set_req(2, 4, 8'h33);
      for (int c = 0; c < 6; c++) begin
         run_cycle(g);
         chk("rr_we3", we3, 1'b1);
         chk("rr_wa3", wa3, 2 + (c % 3));
      end
      for (int i = 0; i < NREQ; i++) r_valid[i] = 1'b0;
      repeat (2) run_cycle(g);

      // clear_req the cycle after a grant to requester 0
      set_req(0, 1, 8'h44);
      set_req(2, 3, 8'h55);
      run_cycle(g);
      chk("clr_pend_we3", we3, 1'b1);
      chk("clr_pend_wd3", wd3, 8'h44);
      r_valid[0] = 1'b0;
      clear_req  = 1'b1;
      run_cycle(g);
      clear_req  = 1'b0;
      chk("clr_we3", we3, 1'b0);
      chk("clr_init_done", init_done, 1'b0);
      for (int k = 0; k < 8; k++) begin
         run_cycle(g);
         if (g >= 0) r_valid[g] = 1'b0;
      end
      chk("clr_post_wa3", wa3, 3);
      chk("clr_post_wd3", wd3, 8'h55);
      run_cycle(g);

      // write to r0 is consumed but not performed
      set_req(0, 0, 8'hFF);
      run_cycle(g);
      chk("r0_we3", we3, 1'b0);
      chk("r0_wd3", wd3, 8'hFF);
      r_valid[0] = 1'b0;
      repeat (2) run_cycle(g);
      chk("r0_unchanged", rf[0], 8'hEE);

      // asynchronous reset while a write is on the port
      set_req(1, 4, 8'h9C);
      run_cycle(g);
      chk("ar_pre_we3", we3, 1'b1);
      #2 rst_n = 1'b0;
      r_valid[1] = 1'b0;
      #1;
      chk("ar_we3", we3, 1'b0);
      chk("ar_init_done", init_done, 1'b0);
      chk("ar_req_ready", req_ready, 0);
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      set_req(0, 2, 8'h12);
      set_req(1, 2, 8'h34);
      run_cycle(g);
      chk("ar_restart_wa3", wa3, 1);
      chk("ar_restart_we3", we3, 1'b1);
      for (int k = 0; k < 10; k++) begin
         run_cycle(g);
         if (g >= 0) r_valid[g] = 1'b0;
      end
      chk("same_addr_last_wins", rf[2], 8'h34);

      // randomized traffic with occasional clears
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!r_valid[i] && $urandom_range(2) == 0) begin
               set_req(i, int'($urandom_range(NREGS - 1)), int'($urandom_range(255)));
            end
         end
         clear_req = ($urandom_range(59) == 0);
         run_cycle(g);
         clear_req = 1'b0;
         if (g >= 0) r_valid[g] = 1'b0;
      end
      for (int i = 0; i < NREQ; i++) r_valid[i] = 1'b0;
      for (int k = 0; k < 12; k++) run_cycle(g);
      for (int r = 0; r < NREGS; r++) chk("final_rf", rf[r], model_rf[r]);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Owns the single write port (wa3/wd3/we3) of the 8-bit MIPS register file.
- After reset it runs a zero-fill sequence over r1..r7, because the register array itself has no reset.
- It then shares the write port between NREQ writeback requesters (ALU, load path, debug host) using round-robin valid/ready arbitration.
- Sits between the writeback sources and RegisterFile, driving wa3/wd3/we3 directly.

Parameters:
- NREQ, 3, number of write requesters (2..4).
- DW, 8, data width.
- AW, 3, register address width; NREGS = 2**AW.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear_req  in  1  one-cycle pulse; restarts the zero-fill sequence.
- req_valid  in  NREQ  per-requester write request.
- req_addr  in  NREQ*AW  packed addresses; requester i at [i*AW +: AW].
- req_data  in  NREQ*DW  packed data; requester i at [i*DW +: DW].
- req_ready  out  NREQ  per-requester accept, one-hot or zero.
- wa3  out  AW  register file write address (registered).
- wd3  out  DW  register file write data (registered).
- we3  out  1  register file write enable (registered).
- init_done  out  1  high once zero-fill has completed.
- busy  out  1  high while in INIT or while any req_valid is high.

Behaviour:
- Reset is asynchronous on rst_n low; every other register is clocked on the posedge of clk.
- Reset values:
  - we3=0, wa3=0, wd3=0, init_done=0.
  - state=INIT, fill_cnt=1, rr_ptr=0.
  - req_ready=0 during reset, because it is gated by state.
- States:
  - INIT:
    - Each cycle the output registers load wa3=fill_cnt, wd3=0, we3=1.
    - fill_cnt increments each cycle.
    - After the cycle that issues address NREGS-1, the next state is RUN and init_done is set to 1.
    - INIT lasts exactly NREGS-1 = 7 cycles; r0 is never written.
    - req_ready=0 throughout INIT.
  - RUN:
    - Search req_valid starting at index rr_ptr, wrapping modulo NREQ.
    - The first set bit, g, wins: req_ready[g]=1 combinationally in the same cycle.
    - A transfer occurs when req_valid[g] & req_ready[g].
    - On a transfer:
      - Next cycle wa3=req_addr[g], wd3=req_data[g].
      - we3 = (req_addr[g] != 0). A write to r0 is consumed (ready given) but we3 stays 0.
      - rr_ptr <= (g+1) mod NREQ.
    - With no valid requester: we3<=0, rr_ptr holds, wa3/wd3 hold.
- Latency:
  - A request accepted in cycle N drives we3 in cycle N+1.
  - The register updates at the end of N+1.
  - Throughput is one write per cycle.
- Requester rule:
  - Once req_valid[i] rises, addr, data and valid must hold until req_ready[i].
  - Losing requesters see ready=0 and retry on subsequent cycles.
- Simultaneous requests to the same address:
  - Serialised in round-robin order; the later grant wins the final value.
- clear_req:
  - In RUN, it takes priority over arbitration in that cycle: no grant, next state INIT, fill_cnt=1, init_done<=0.
  - A write already registered on wa3/wd3/we3 still completes.
  - A clear_req arriving during INIT restarts fill_cnt at 1.
- rst_n asserted mid-operation: any in-flight we3 is dropped immediately, because we3 is forced to 0 asynchronously.
- init_done is registered: it is 1 from the first RUN cycle onward.
- req_ready must never have more than one bit set.

Decomposition:
- Shared package regfile_pkg holds:
  - The state enum {INIT, RUN}.
  - Constants DW=8, AW=3, NREGS=8 and REG_ZERO=0, reused by RegisterFile users and the datapath.
- One natural sub-module: rr_arbiter.
  - Combinational one-hot round-robin pick from req_valid and rr_ptr, outputting grant and grant_idx.
  - Reusable elsewhere in the design.
- The FSM, fill counter and output registers stay in the top module.

Test Plan:
- Zero-fill:
  - Stimulus: release rst_n with no requests.
  - Required: we3=1 for 7 consecutive cycles with wa3=1..7 and wd3=0, then we3=0, init_done=1, and req_ready stays 0 during those 7 cycles.
- Single write:
  - Stimulus: after init, requester 1 drives addr=5, data=0xA3 for one cycle.
  - Required: req_ready[1]=1 that cycle; next cycle we3=1, wa3=5, wd3=0xA3; the register file then reads rd1=0xA3 for ra1=5.
- Round-robin fairness:
  - Stimulus: all three requesters valid continuously (addrs 2/3/4, data 0x11/0x22/0x33), rr_ptr=0.
  - Required: grant order 0,1,2,0,1,2, one grant per cycle, and the we3 stream matches that order one cycle later.
- r0 discard:
  - Stimulus: requester 0 writes addr=0, data=0xFF.
  - Required: req_ready[0]=1, next cycle we3=0, and the register file r0 is unchanged.
- clear_req mid-stream:
  - Stimulus: requesters 0 and 2 valid, pulse clear_req in the cycle after a grant to 0.
  - Required:
    - The granted write still appears on we3.
    - No grant in the clear cycle.
    - init_done drops, then a 7-cycle fill of r1..r7.
    - Requester 2 is granted only after init_done returns to 1.
- Async reset during traffic:
  - Stimulus: assert rst_n low mid-cycle while we3=1.
  - Required: we3, init_done and req_ready go to 0 immediately, without waiting for a clock edge; after release the zero-fill restarts at wa3=1.
